// File: rtl/axi4lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register file slave.
package axi4lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    // Register index of a byte address; callers zero-extend narrower addresses.
    function automatic int unsigned addr_to_idx(input logic [MAX_DATA_W-1:0] addr,
                                                input int unsigned lsb);
        return 32'(addr >> lsb);
    endfunction

    function automatic logic [MAX_DATA_W-1:0] apply_wstrb(input logic [MAX_DATA_W-1:0] old_data,
                                                          input logic [MAX_DATA_W-1:0] new_data,
                                                          input logic [MAX_STRB_W-1:0] strb);
        logic [MAX_DATA_W-1:0] merged;
        merged = old_data;
        for (int k = 0; k < MAX_STRB_W; k++) begin
            if (strb[k]) begin
                merged[k*8 +: 8] = new_data[k*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4lite_regfile_core.sv
// Register array: byte-strobe merge, read-only masking, write pulses and read mux.
module axi4lite_regfile_core
    import axi4lite_pkg::*;
#(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   REG_COUNT  = 4,
    parameter logic [REG_COUNT-1:0] RO_MASK    = '0,
    parameter int                   IDX_W      = 2
) (
    input  logic                            aclk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [IDX_W-1:0]                wr_idx,
    input  logic [DATA_WIDTH-1:0]           wr_data,
    input  logic [DATA_WIDTH/8-1:0]         wr_strb,
    input  logic [IDX_W-1:0]                rd_idx,
    output logic [DATA_WIDTH-1:0]           rd_data,
    input  logic [REG_COUNT*DATA_WIDTH-1:0] hw_in,
    output logic [REG_COUNT*DATA_WIDTH-1:0] reg_out,
    output logic [REG_COUNT-1:0]            reg_wr_pulse
);

    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
    logic [REG_COUNT-1:0]  wr_pulse_q, wr_pulse_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        regs_d     = regs_q;
        wr_pulse_d = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (wr_en && !RO_MASK[i] && (int'(wr_idx) == i)) begin
                regs_d[i]     = DATA_WIDTH'(apply_wstrb(64'(regs_q[i]), 64'(wr_data),
                                                        8'(wr_strb)));
                wr_pulse_d[i] = |wr_strb;
            end
        end
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            // NOTE: the array is reset on purpose; software expects every register to read 0 after reset.
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
            wr_pulse_q <= '0;
        end else begin
            // NOTE: state updates use <= so every flop samples pre-edge values, whatever the statement order.
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    always_comb begin
        reg_out = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (!RO_MASK[i]) begin
                reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
            end
        end
    end

    // Read mux sees pre-edge register contents, so a same-edge write is not visible.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (int'(rd_idx) == i) begin
                rd_data = RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            end
        end
    end

    assign reg_wr_pulse = wr_pulse_q;

endmodule

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite slave endpoint: independent write and read FSMs in front of a register file core.
module axi4lite_regfile_slave
    import axi4lite_pkg::*;
#(
    parameter int                   ADDR_WIDTH = 4,
    parameter int                   DATA_WIDTH = 32,
    parameter int                   REG_COUNT  = 4,
    parameter logic [REG_COUNT-1:0] RO_MASK    = '0
) (
    input  logic                            aclk,
    input  logic                            rst,
    input  logic [ADDR_WIDTH-1:0]           AWADDR,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [DATA_WIDTH-1:0]           WDATA,
    input  logic [DATA_WIDTH/8-1:0]         WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [ADDR_WIDTH-1:0]           ARADDR,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [DATA_WIDTH-1:0]           RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic [REG_COUNT*DATA_WIDTH-1:0] reg_out,
    input  logic [REG_COUNT*DATA_WIDTH-1:0] hw_in,
    output logic [REG_COUNT-1:0]            reg_wr_pulse
);

    localparam int          STRB_W      = DATA_WIDTH / 8;
    localparam int unsigned LSB         = $clog2(STRB_W);
    localparam int          IDX_W       = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam int unsigned REG_COUNT_U = REG_COUNT;

    function automatic logic is_ro(input logic [IDX_W-1:0] idx);
        logic ro;
        ro = 1'b0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (int'(idx) == i) begin
                ro = RO_MASK[i];
            end
        end
        return ro;
    endfunction

    // Write channel state
    wr_state_t             wr_state_q, wr_state_d;
    logic                  aw_cap_q, aw_cap_d;
    logic                  w_cap_q, w_cap_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    resp_t                 bresp_q, bresp_d;

    logic                  aw_hs, w_hs, commit, wr_ok, wr_in_range;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic [IDX_W-1:0]      wr_idx;

    // Read channel state
    rd_state_t             rd_state_q, rd_state_d;
    logic                  rvalid_q, rvalid_d;
    resp_t                 rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  ar_hs, rd_in_range;
    logic [IDX_W-1:0]      rd_idx;
    logic [DATA_WIDTH-1:0] core_rd_data;

    // Readies are gated by rst so they are low during reset and high right after it.
    assign AWREADY = !rst && (wr_state_q == W_IDLE) && !aw_cap_q;
    assign WREADY  = !rst && (wr_state_q == W_IDLE) && !w_cap_q;
    assign ARREADY = !rst && (rd_state_q == R_IDLE);

    assign aw_hs = AWVALID && AWREADY;
    assign w_hs  = WVALID && WREADY;
    assign ar_hs = ARVALID && ARREADY;

    // The commit uses whichever payload is live this cycle: latched or on the bus.
    always_comb begin
        wr_addr     = aw_cap_q ? awaddr_q : AWADDR;
        wr_data     = w_cap_q ? wdata_q : WDATA;
        wr_strb     = w_cap_q ? wstrb_q : WSTRB;
        wr_idx      = IDX_W'(addr_to_idx(64'(wr_addr), LSB));
        wr_in_range = addr_to_idx(64'(wr_addr), LSB) < REG_COUNT_U;
        wr_ok       = wr_in_range && !is_ro(wr_idx);
    end

    always_comb begin
        wr_state_d = wr_state_q;
        aw_cap_d   = aw_cap_q;
        w_cap_d    = w_cap_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        commit     = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_cap_d = 1'b1;
                    awaddr_d = AWADDR;
                end
                if (w_hs) begin
                    w_cap_d = 1'b1;
                    wdata_d = WDATA;
                    wstrb_d = WSTRB;
                end
                if ((aw_cap_q || aw_hs) && (w_cap_q || w_hs)) begin
                    commit     = 1'b1;
                    aw_cap_d   = 1'b0;
                    w_cap_d    = 1'b0;
                    bvalid_d   = 1'b1;
                    bresp_d    = wr_ok ? OKAY : SLVERR;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    bvalid_d   = 1'b0;
                    wr_state_d = W_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            aw_cap_q   <= 1'b0;
            w_cap_q    <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_cap_q   <= aw_cap_d;
            w_cap_q    <= w_cap_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
        end
    end

    always_comb begin
        rd_idx      = IDX_W'(addr_to_idx(64'(ARADDR), LSB));
        rd_in_range = addr_to_idx(64'(ARADDR), LSB) < REG_COUNT_U;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rvalid_d   = rvalid_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rvalid_d   = 1'b1;
                    rresp_d    = rd_in_range ? OKAY : SLVERR;
                    rdata_d    = rd_in_range ? core_rd_data : '0;
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (RREADY) begin
                    rvalid_d   = 1'b0;
                    rd_state_d = R_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or posedge rst) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rvalid_q   <= 1'b0;
            rresp_q    <= OKAY;
            rdata_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    axi4lite_regfile_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .RO_MASK    (RO_MASK),
        .IDX_W      (IDX_W)
    ) u_core (
        .aclk         (aclk),
        .rst          (rst),
        .wr_en        (commit && wr_ok),
        .wr_idx       (wr_idx),
        .wr_data      (wr_data),
        .wr_strb      (wr_strb),
        .rd_idx       (rd_idx),
        .rd_data      (core_rd_data),
        .hw_in        (hw_in),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse)
    );

    assign BVALID = bvalid_q;
    assign BRESP  = bresp_q;
    assign RVALID = rvalid_q;
    assign RRESP  = rresp_q;
    assign RDATA  = rdata_q;

endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Self-checking bench: vector table plus scoreboard queues, and hand-written corner sequences.
module tb_axi4lite_regfile_slave;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int RC = 4;
    localparam logic [RC-1:0] RO = 4'b0100;
    localparam logic [1:0] R_OK  = 2'b00;
    localparam logic [1:0] R_ERR = 2'b10;

    logic              aclk = 1'b0;
    logic              rst;
    logic [AW-1:0]     AWADDR, ARADDR;
    logic              AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic              ARVALID, ARREADY, RVALID, RREADY;
    logic [DW-1:0]     WDATA, RDATA;
    logic [3:0]        WSTRB;
    logic [1:0]        BRESP, RRESP;
    logic [RC*DW-1:0]  reg_out, hw_in;
    logic [RC-1:0]     reg_wr_pulse;

    always #5 aclk = ~aclk;

    axi4lite_regfile_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .REG_COUNT  (RC),
        .RO_MASK    (RO)
    ) dut (
        .aclk         (aclk),
        .rst          (rst),
        .AWADDR       (AWADDR),
        .AWVALID      (AWVALID),
        .AWREADY      (AWREADY),
        .WDATA        (WDATA),
        .WSTRB        (WSTRB),
        .WVALID       (WVALID),
        .WREADY       (WREADY),
        .BRESP        (BRESP),
        .BVALID       (BVALID),
        .BREADY       (BREADY),
        .ARADDR       (ARADDR),
        .ARVALID      (ARVALID),
        .ARREADY      (ARREADY),
        .RDATA        (RDATA),
        .RRESP        (RRESP),
        .RVALID       (RVALID),
        .RREADY       (RREADY),
        .reg_out      (reg_out),
        .hw_in        (hw_in),
        .reg_wr_pulse (reg_wr_pulse)
    );

    typedef struct {
        logic             is_wr;
        logic [AW-1:0]    addr;
        logic [DW-1:0]    data;
        logic [3:0]       strb;
        int               w_lead;
        logic [1:0]       exp_resp;
        logic [DW-1:0]    exp_rdata;
        logic [RC-1:0]    exp_pulse;
        logic [RC*DW-1:0] exp_regout;
    } vec_t;

    typedef struct {
        logic [1:0]    resp;
        logic [DW-1:0] data;
        logic [RC-1:0] pulse;
    } exp_t;

    exp_t bq[$];
    exp_t rq[$];
    vec_t vecs[14];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic vec_t mk(input logic is_wr, input logic [AW-1:0] addr,
                                input logic [DW-1:0] data, input logic [3:0] strb,
                                input int w_lead, input logic [1:0] exp_resp,
                                input logic [DW-1:0] exp_rdata, input logic [RC-1:0] exp_pulse,
                                input logic [RC*DW-1:0] exp_regout);
        vec_t v;
        v.is_wr = is_wr; v.addr = addr; v.data = data; v.strb = strb; v.w_lead = w_lead;
        v.exp_resp = exp_resp; v.exp_rdata = exp_rdata; v.exp_pulse = exp_pulse;
        v.exp_regout = exp_regout;
        return v;
    endfunction

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, input int w_lead);
        WDATA = data; WSTRB = strb; WVALID = 1'b1;
        if (w_lead > 0) begin
            for (int i = 0; i < 16 && !WREADY; i++) tick();
            check("w_first_wready", WREADY, 1);
            tick();
            WVALID = 1'b0;
            for (int i = 0; i < w_lead; i++) begin
                check("wait_awready", AWREADY, 1);
                check("wait_wready", WREADY, 0);
                check("wait_bvalid", BVALID, 0);
                if (i != w_lead - 1) tick();
            end
        end
        AWADDR = addr; AWVALID = 1'b1;
        for (int i = 0; i < 16 && !(AWREADY && (WREADY || !WVALID)); i++) tick();
        check("awready", AWREADY, 1);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
    endtask

    task automatic collect_b(input logic [RC*DW-1:0] exp_regout);
        exp_t e;
        e = bq.pop_front();
        check("bvalid", BVALID, 1);
        check("bresp", BRESP, e.resp);
        check("wr_pulse", reg_wr_pulse, e.pulse);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        check("bvalid_clr", BVALID, 0);
        check("wr_pulse_clr", reg_wr_pulse, 0);
        check("reg_out", reg_out, exp_regout);
    endtask

    task automatic do_read(input logic [AW-1:0] addr);
        ARADDR = addr; ARVALID = 1'b1;
        for (int i = 0; i < 16 && !ARREADY; i++) tick();
        check("arready", ARREADY, 1);
        tick();
        ARVALID = 1'b0;
    endtask

    task automatic collect_r(input logic [RC*DW-1:0] exp_regout);
        exp_t e;
        e = rq.pop_front();
        check("rvalid", RVALID, 1);
        check("rdata", RDATA, e.data);
        check("rresp", RRESP, e.resp);
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        check("rvalid_clr", RVALID, 0);
        check("reg_out_rd", reg_out, exp_regout);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [RC*DW-1:0] r1, r2, r3, r4, r5;
        r1 = {32'h0, 32'h0, 32'hDEADBEEF, 32'h0};
        r2 = {32'h0, 32'h0, 32'hDEADBEEF, 32'hFFFFFFFF};
        r3 = {32'h0, 32'h0, 32'hDEADBEEF, 32'hFF22FF44};
        r4 = {32'h0A0B0000, 32'h0, 32'hDEADBEEF, 32'hFF22FF44};
        r5 = {32'h0A0B0000, 32'h0, 32'h01020304, 32'hFF22FF44};

        vecs[0]  = mk(1, 5'h04, 32'hDEADBEEF, 4'hF, 0, R_OK,  32'h0,        4'b0010, r1);
        vecs[1]  = mk(0, 5'h04, 32'h0,        4'h0, 0, R_OK,  32'hDEADBEEF, 4'b0000, r1);
        vecs[2]  = mk(1, 5'h00, 32'hFFFFFFFF, 4'hF, 0, R_OK,  32'h0,        4'b0001, r2);
        vecs[3]  = mk(1, 5'h00, 32'h11223344, 4'h5, 3, R_OK,  32'h0,        4'b0001, r3);
        vecs[4]  = mk(0, 5'h00, 32'h0,        4'h0, 0, R_OK,  32'hFF22FF44, 4'b0000, r3);
        vecs[5]  = mk(1, 5'h10, 32'h12345678, 4'hF, 0, R_ERR, 32'h0,        4'b0000, r3);
        vecs[6]  = mk(0, 5'h10, 32'h0,        4'h0, 0, R_ERR, 32'h0,        4'b0000, r3);
        vecs[7]  = mk(0, 5'h08, 32'h0,        4'h0, 0, R_OK,  32'hCAFE0001, 4'b0000, r3);
        vecs[8]  = mk(1, 5'h08, 32'h55555555, 4'hF, 0, R_ERR, 32'h0,        4'b0000, r3);
        vecs[9]  = mk(1, 5'h0E, 32'h0A0B0C0D, 4'hC, 1, R_OK,  32'h0,        4'b1000, r4);
        vecs[10] = mk(0, 5'h0F, 32'h0,        4'h0, 0, R_OK,  32'h0A0B0000, 4'b0000, r4);
        vecs[11] = mk(1, 5'h04, 32'h0,        4'h0, 0, R_OK,  32'h0,        4'b0000, r4);
        vecs[12] = mk(0, 5'h05, 32'h0,        4'h0, 0, R_OK,  32'hDEADBEEF, 4'b0000, r4);
        vecs[13] = mk(0, 5'h1C, 32'h0,        4'h0, 0, R_ERR, 32'h0,        4'b0000, r4);

        hw_in = {32'h77777777, 32'hCAFE0001, 32'h5A5A5A5A, 32'h0BAD0BAD};
        AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
        ARADDR = '0; ARVALID = 0; RREADY = 0;
        rst = 1'b1;

        repeat (2) tick();
        check("rst_awready", AWREADY, 0);
        check("rst_wready", WREADY, 0);
        check("rst_arready", ARREADY, 0);
        check("rst_bvalid", BVALID, 0);
        check("rst_rvalid", RVALID, 0);
        check("rst_reg_out", reg_out, 0);
        check("rst_pulse", reg_wr_pulse, 0);
        rst = 1'b0;
        #1;
        check("post_rst_awready", AWREADY, 1);
        check("post_rst_wready", WREADY, 1);
        check("post_rst_arready", ARREADY, 1);

        for (int v = 0; v < 14; v++) begin
            e.resp = vecs[v].exp_resp; e.data = vecs[v].exp_rdata; e.pulse = vecs[v].exp_pulse;
            if (vecs[v].is_wr) begin
                bq.push_back(e);
                do_write(vecs[v].addr, vecs[v].data, vecs[v].strb, vecs[v].w_lead);
                collect_b(vecs[v].exp_regout);
            end else begin
                rq.push_back(e);
                do_read(vecs[v].addr);
                collect_r(vecs[v].exp_regout);
            end
        end

        // Same-edge write and read of register 1, then hold both responses under backpressure.
        AWADDR = 5'h04; WDATA = 32'h01020304; WSTRB = 4'hF; ARADDR = 5'h04;
        AWVALID = 1; WVALID = 1; ARVALID = 1;
        e.resp = R_OK; e.data = 32'h0; e.pulse = 4'b0010; bq.push_back(e);
        e.resp = R_OK; e.data = 32'hDEADBEEF; e.pulse = 4'b0000; rq.push_back(e);
        check("bp_readies", {AWREADY, WREADY, ARREADY}, 3'b111);
        tick();
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        e = bq.pop_front();
        check("bp_pulse", reg_wr_pulse, e.pulse);
        check("bp_bresp0", BRESP, e.resp);
        e = rq.pop_front();
        for (int c = 0; c < 5; c++) begin
            check("bp_bvalid", BVALID, 1);
            check("bp_bresp", BRESP, R_OK);
            check("bp_rvalid", RVALID, 1);
            check("bp_rdata", RDATA, e.data);
            check("bp_rresp", RRESP, e.resp);
            check("bp_readies_low", {AWREADY, WREADY, ARREADY}, 3'b000);
            check("bp_reg_out", reg_out, r5);
            tick();
            check("bp_pulse_clr", reg_wr_pulse, 0);
        end
        BREADY = 1; RREADY = 1;
        tick();
        BREADY = 0; RREADY = 0;
        check("bp_release_valids", {BVALID, RVALID}, 2'b00);
        check("bp_release_readies", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Reset with W captured and AW pending: nothing may be written.
        WDATA = 32'hFFFFFFFF; WSTRB = 4'hF; WVALID = 1;
        tick();
        WVALID = 0;
        check("rst_seq_wcap_awready", AWREADY, 1);
        check("rst_seq_wcap_wready", WREADY, 0);
        rst = 1; AWADDR = 5'h00; AWVALID = 1;
        #1;
        check("rst_seq_readies", {AWREADY, WREADY, ARREADY}, 3'b000);
        check("rst_seq_reg_out", reg_out, 0);
        tick();
        tick();
        AWVALID = 0; rst = 0;
        #1;
        check("rst_seq_readies_up", {AWREADY, WREADY, ARREADY}, 3'b111);
        repeat (3) tick();
        check("rst_seq_bvalid", BVALID, 0);
        check("rst_seq_pulse", reg_wr_pulse, 0);
        check("rst_seq_reg_out2", reg_out, 0);
        for (int a = 0; a < 4; a++) begin
            e.resp = R_OK; e.pulse = 4'b0000;
            e.data = (a == 2) ? 32'hCAFE0001 : 32'h0;
            rq.push_back(e);
            do_read(5'(a * 4));
            collect_r({RC*DW{1'b0}});
        end

        // AW alone after reset must wait for fresh W data.
        AWADDR = 5'h00; AWVALID = 1;
        tick();
        AWVALID = 0;
        check("aw_only_bvalid", BVALID, 0);
        check("aw_only_awready", AWREADY, 0);
        check("aw_only_wready", WREADY, 1);
        tick();
        check("aw_only_bvalid2", BVALID, 0);
        e.resp = R_OK; e.data = 32'h0; e.pulse = 4'b0001; bq.push_back(e);
        WDATA = 32'h13579BDF; WSTRB = 4'hF; WVALID = 1;
        tick();
        WVALID = 0;
        collect_b({32'h0, 32'h0, 32'h0, 32'h13579BDF});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi4lite_regfile_slave.md
Name: axi4lite_regfile_slave

Overview:
- Parametrised AXI4-Lite slave register file; the next generation of the team's AXI4-Lite interface, now a full slave endpoint.
- Implements REG_COUNT data-wide registers with per-register read-only/read-write mode, byte strobes and decode errors.
- Accepts write address and write data independently, in either order, and runs reads concurrently with writes.
- Sits between the AXI4-Lite interconnect and core control/status logic.

Parameters:
ADDR_WIDTH, 4, byte-address width; must hold REG_COUNT*(DATA_WIDTH/8) bytes.
DATA_WIDTH, 32, data bus width; 32 or 64.
REG_COUNT, 4, number of registers, at least 1.
RO_MASK, '0, REG_COUNT bits; bit i=1 makes register i read-only, sourced from hw_in.

Ports:
aclk  in  1  clock.
rst  in  1  asynchronous active-high reset.
AWADDR  in  ADDR_WIDTH  write address.
AWVALID/AWREADY  in/out  1  write address handshake.
WDATA  in  DATA_WIDTH  write data.
WSTRB  in  DATA_WIDTH/8  byte strobes.
WVALID/WREADY  in/out  1  write data handshake.
BRESP  out  2  write response.
BVALID/BREADY  out/in  1  write response handshake.
ARADDR  in  ADDR_WIDTH  read address.
ARVALID/ARREADY  in/out  1  read address handshake.
RDATA  out  DATA_WIDTH  read data.
RRESP  out  2  read response.
RVALID/RREADY  out/in  1  read data handshake.
reg_out  out  REG_COUNT*DATA_WIDTH  flat contents of RW registers; RO slots drive 0.
hw_in  in  REG_COUNT*DATA_WIDTH  status values returned for RO registers.
reg_wr_pulse  out  REG_COUNT  one-cycle pulse when register i is written.

Behaviour:
- Reset state:
  - rst=1 asynchronously clears all registers, reg_out, reg_wr_pulse, BVALID, RVALID, BRESP, RRESP, RDATA and the internal captured flags.
  - AWREADY, WREADY and ARREADY are 0 while rst=1.
  - All three ready signals are 1 in the first cycle after rst falls.
- Address decode:
  - idx = addr[ADDR_WIDTH-1:LSB], with LSB = log2(DATA_WIDTH/8); low address bits are ignored.
  - idx >= REG_COUNT returns SLVERR (2'b10). All other accesses return OKAY (2'b00), except writes to RO registers.
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE: AWREADY = !aw_captured and WREADY = !w_captured.
  - Each handshake latches its payload and sets its captured flag. AW and W may complete in the same cycle or in either order, with any gap between them.
  - On the edge where both flags become set: commit the write, set BVALID=1, clear both flags, drop AWREADY/WREADY, and move to W_RESP.
  - The commit updates bytes where WSTRB[k]=1 and leaves the rest unchanged. Write latency is 1 cycle from the last handshake to BVALID.
  - reg_wr_pulse[idx] is high for exactly the first cycle of W_RESP, and only for an OKAY write with at least one strobe set.
  - Write to an RO register: BRESP=SLVERR, register unchanged, no pulse. Out-of-range write: SLVERR, nothing changes.
  - W_RESP: BVALID and BRESP are held stable until BREADY=1. On that edge go to W_IDLE with both readies 1 in the next cycle.
- Read FSM, states R_IDLE, R_RESP:
  - R_IDLE: ARREADY=1. On handshake, RDATA/RRESP are registered and RVALID=1 on the next cycle.
  - RDATA source: register value for RW, hw_in slice for RO, 0 for out of range.
  - R_RESP: ARREADY=0; RDATA, RRESP and RVALID are held until RREADY=1, then return to R_IDLE.
  - Single outstanding read and single outstanding write at a time.
- Simultaneous events:
  - A read and a write commit to the same register on the same edge: the read returns the pre-write value.
  - Read and write channels never stall each other.
  - hw_in is sampled at the AR handshake edge.
- Reset mid-operation: any pending captured AW/W and any outstanding B/R response are discarded. No write commits on the reset edge.

Decomposition:
- Package axi4lite_pkg:
  - resp_t enum with OKAY=2'b00 and SLVERR=2'b10.
  - wr_state_t {W_IDLE, W_RESP} and rd_state_t {R_IDLE, R_RESP}.
  - Function addr_to_idx.
  - Function apply_wstrb (byte-merge old data with new data under strobes).
- One natural sub-module: axi4lite_regfile_core, the register array with strobe merge, RO masking and wr_pulse generation. The top level holds the two FSMs.

Test Plan:
- AW and W in the same cycle: addr 0x4, data 0xDEADBEEF, strb 0xF -> BVALID one cycle later with BRESP=00; reg_wr_pulse[1] for 1 cycle; reg_out slot 1 = 0xDEADBEEF; read 0x4 returns 0xDEADBEEF with OKAY.
- W three cycles before AW, then partial strobe: addr 0x0, data 0x11223344, strb 0x5 onto prior 0xFFFFFFFF -> reg0 = 0xFF22FF44, BRESP=00; AWREADY=1 but WREADY=0 while waiting for AW.
- Out-of-range access with REG_COUNT=4: write 0x10 and read 0x10 -> BRESP=10, RRESP=10, RDATA=0; no register changes and no pulse.
- RO_MASK=4'b0100, hw_in slot 2 = 0xCAFE0001: read 0x8 -> 0xCAFE0001, OKAY; write 0x8 -> SLVERR, no pulse.
- Backpressure: BREADY and RREADY held low for 5 cycles -> BVALID/RVALID and their payloads stay stable, AWREADY/WREADY/ARREADY stay 0; both complete on release.
- rst asserted while W is captured and AW is pending -> after release, no write has occurred, all registers read 0, all readies are 1.
